// File: rtl/reset_sequencer.sv
// Staged reset release controller: synchronizes reset deassertion, drops stage
// resets one by one with a fixed gap, then runs a loadable timeout counter.
module reset_sequencer #(
    parameter int unsigned SYNC_DEPTH = 2,
    parameter int unsigned N_STAGES   = 3,
    parameter int unsigned STAGE_GAP  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                count_load,
    input  logic [31:0]         count_value,
    output logic [N_STAGES-1:0] stage_reset,
    output logic                all_released,
    output logic [31:0]         cycles_remaining,
    output logic                count_busy,
    output logic                count_reached
);

    localparam int unsigned CNT_W = 32;
    localparam int unsigned GAP_W = 8;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t                state_q;
    logic [SYNC_DEPTH-1:0] sync_q;
    logic [GAP_W-1:0]      gap_q;
    logic [N_STAGES-1:0]   stage_q;
    logic                  all_rel_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  busy_q;
    logic                  reached_q;
    logic                  reached_d;
    logic                  hold_exit;

    // True exactly on the edge where the synchronized reset output drops.
    assign hold_exit = sync_q[SYNC_DEPTH-1] & ~sync_q[SYNC_DEPTH-2];

    // Timeout counter next state; a load always wins over the decrement.
    always_comb begin
        cnt_d     = cnt_q;
        reached_d = 1'b0;
        if (state_q == RUN) begin
            if (count_load) begin
                cnt_d     = count_value;
                reached_d = (count_value == '0);
            end else if (cnt_q != '0) begin
                cnt_d     = cnt_q - CNT_W'(1);
                reached_d = (cnt_q == CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '1;
            state_q   <= HOLD;
            gap_q     <= '0;
            stage_q   <= '1;
            all_rel_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            reached_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_DEPTH-2:0], 1'b0};
            cnt_q     <= cnt_d;
            busy_q    <= (cnt_d != '0);
            reached_q <= reached_d;
            case (state_q)
                HOLD: begin
                    if (hold_exit) begin
                        state_q <= RELEASE;
                        gap_q   <= '0;
                    end
                end
                RELEASE: begin
                    // Shifting left clears bit 0 first, then the next bit up.
                    if (stage_q == '0) begin
                        state_q   <= RUN;
                        all_rel_q <= 1'b1;
                    end else if (gap_q == '0) begin
                        stage_q <= stage_q << 1;
                        gap_q   <= GAP_RELOAD;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    assign stage_reset      = stage_q;
    assign all_released     = all_rel_q;
    assign cycles_remaining = cnt_q;
    assign count_busy       = busy_q;
    assign count_reached    = reached_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: an edge-count reference model queues
// expected outputs per cycle, and a negedge monitor compares them.
module tb_reset_sequencer;

    localparam int SD   = 2;
    localparam int NS   = 3;
    localparam int GAP  = 4;
    localparam int T0   = SD;
    localparam int TREL = T0 + (NS - 1) * GAP + 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          count_load;
    logic [31:0]   count_value;
    logic [NS-1:0] stage_reset;
    logic          all_released;
    logic [31:0]   cycles_remaining;
    logic          count_busy;
    logic          count_reached;

    reset_sequencer #(
        .SYNC_DEPTH (SD),
        .N_STAGES   (NS),
        .STAGE_GAP  (GAP)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .count_load       (count_load),
        .count_value      (count_value),
        .stage_reset      (stage_reset),
        .all_released     (all_released),
        .cycles_remaining (cycles_remaining),
        .count_busy       (count_busy),
        .count_reached    (count_reached)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        logic [NS-1:0] stage;
        logic          all_rel;
        logic [31:0]   rem;
        logic          busy;
        logic          reached;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: edges seen since reset fell, plus the timeout count.
    int          m_n;
    int unsigned m_rem;
    logic        m_reached;

    task automatic model_reset();
        m_n       = 0;
        m_rem     = 0;
        m_reached = 1'b0;
    endtask

    task automatic model_edge();
        if (reset !== 1'b1) begin
            m_n = m_n + 1;
            if (m_n - 1 >= TREL) begin
                if (count_load) begin
                    m_rem     = count_value;
                    m_reached = (count_value == 0);
                end else if (m_rem > 0) begin
                    m_rem     = m_rem - 1;
                    m_reached = (m_rem == 0);
                end else begin
                    m_reached = 1'b0;
                end
            end else begin
                m_rem     = 0;
                m_reached = 1'b0;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < NS; k++) e.stage[k] = (m_n < T0 + k * GAP + 1);
        e.all_rel = (m_n >= TREL);
        e.rem     = m_rem;
        e.busy    = (m_rem != 0);
        e.reached = m_reached;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic ld, input int unsigned val);
        @(posedge clock);
        model_edge();
        #2;
        reset       = r;
        count_load  = ld;
        count_value = val;
        if (r) model_reset();
        push_exp();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stage_reset", 32'(stage_reset), 32'(e.stage));
                chk("all_released", 32'(all_released), 32'(e.all_rel));
                chk("cycles_remaining", cycles_remaining, e.rem);
                chk("count_busy", 32'(count_busy), 32'(e.busy));
                chk("count_reached", 32'(count_reached), 32'(e.reached));
            end
        end
    end

    initial begin : stimulus
        reset       = 1'b1;
        count_load  = 1'b0;
        count_value = '0;
        model_reset();

        repeat (3) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        idle(4);
        cycle(1'b0, 1'b1, 7);
        idle(12);

        cycle(1'b0, 1'b1, 5);
        idle(8);
        cycle(1'b0, 1'b1, 0);
        idle(3);

        cycle(1'b0, 1'b1, 10);
        idle(6);
        cycle(1'b0, 1'b1, 3);
        idle(6);

        cycle(1'b0, 1'b1, 2);
        idle(1);
        cycle(1'b0, 1'b1, 4);
        idle(6);

        cycle(1'b0, 1'b1, 8);
        idle(3);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        idle(4);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        idle(16);

        repeat (600) begin
            logic        r;
            logic        ld;
            int unsigned val;
            r   = ($urandom_range(0, 99) < 2);
            ld  = ($urandom_range(0, 5) == 0);
            val = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
            if (r) begin
                repeat ($urandom_range(1, 3)) cycle(1'b1, ld, val);
                cycle(1'b0, 1'b0, 0);
            end else begin
                cycle(1'b0, ld, val);
            end
        end
        idle(2);

        repeat (2) @(negedge clock);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
